deslocador_universal_shift: RTL and testbench



---
 rtl/deslocador_universal_shift.sv | 49 ++++
 tb/tb_deslocador_universal_shift.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/deslocador_universal_shift.sv
// Universal shift register: parallel load, left/right shift with separate serial inputs.
// Optional freeze input `hold` is built in when DESLOCADOR_HOLD_EN is defined.
module deslocador_universal_shift #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [size-1:0] E,
    input  logic            Er,
    input  logic            El,
    input  logic            load,
    input  logic            dir,
`ifdef DESLOCADOR_HOLD_EN
    input  logic            hold,
`endif
    output logic [size-1:0] Y
);

    logic [size-1:0] r;
    logic [size-1:0] r_next;

    // Priority: hold (if built) > load > shift; there is no idle state without hold.
    always_comb begin
        r_next = r;
`ifdef DESLOCADOR_HOLD_EN
        if (hold) begin
            r_next = r;
        end else
`endif
        if (load) begin
            r_next = E;
        end else if (!dir) begin
            r_next = {r[size-2:0], Er};
        end else begin
            r_next = {El, r[size-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else begin
            r <= r_next;
        end
    end

    assign Y = r;

endmodule

// File: tb/tb_deslocador_universal_shift.sv
// Self-checking bench for deslocador_universal_shift (size = 4): vector table,
// corner sequences, and randomized stimulus against an arithmetic reference model.
module tb_deslocador_universal_shift;

    localparam int SIZE = 4;

    logic            clk;
    logic            rst_n;
    logic [SIZE-1:0] e;
    logic            er;
    logic            el;
    logic            load;
    logic            dir;
    logic [SIZE-1:0] y;
`ifdef DESLOCADOR_HOLD_EN
    logic            hold;
`endif

    int assertions;
    int failures;
    int model;

    deslocador_universal_shift #(.size(SIZE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (e),
        .Er   (er),
        .El   (el),
        .load (load),
        .dir  (dir),
`ifdef DESLOCADOR_HOLD_EN
        .hold (hold),
`endif
        .Y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            ld;
        logic            dr;
        logic            r_in;
        logic            l_in;
        logic [SIZE-1:0] data;
        logic [SIZE-1:0] expected;
    } vec_t;

    vec_t vecs[$];

    // Reference: shifts expressed as integer multiply/divide on the register value.
    function automatic int ref_next(int cur, logic ld, logic dr, logic r_in, logic l_in, int data);
        if (ld)
            return data;
        else if (!dr)
            return (cur * 2 + int'(r_in)) % (1 << SIZE);
        else
            return cur / 2 + int'(l_in) * (1 << (SIZE - 1));
    endfunction

    task automatic applyStimulus(input logic ld, input logic dr, input logic r_in,
                                 input logic l_in, input logic [SIZE-1:0] data);
        @(negedge clk);
        load = ld;
        dir  = dr;
        er   = r_in;
        el   = l_in;
        e    = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [SIZE-1:0] expected);
        assertions++;
        if (y !== expected) begin
            failures++;
            $display("[TB] FAIL %s: Y=%b expected %b", name, y, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertions = 0;
        failures   = 0;
        rst_n = 1'b0;
        load  = 1'b0;
        dir   = 1'b0;
        er    = 1'b0;
        el    = 1'b0;
        e     = '0;
`ifdef DESLOCADOR_HOLD_EN
        hold  = 1'b0;
`endif

        #12;
        checkOutput("reset_state", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0111});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1110});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1100});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1110});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, 4'b1100});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ld, vecs[i].dr, vecs[i].r_in, vecs[i].l_in, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].expected);
        end

        // Asynchronous reset in mid-cycle clears Y before any edge.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        checkOutput("pre_reset_load", 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("reset_held_through_edge", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
        checkOutput("first_edge_after_reset", 4'b0101);

        // No combinational path: input changes between edges leave Y alone.
        #1;
        load = 1'b1;
        e    = 4'b1010;
        dir  = 1'b1;
        el   = 1'b1;
        #2;
        checkOutput("no_comb_path", 4'b0101);

        // Load held high reloads on every edge.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0011);
        checkOutput("load_hold_1", 4'b0011);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1001);
        checkOutput("load_hold_2", 4'b1001);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0110);
        checkOutput("load_hold_3", 4'b0110);

`ifdef DESLOCADOR_HOLD_EN
        @(negedge clk);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b1001);
            checkOutput($sformatf("hold_freeze%0d", k), 4'b0110);
        end
        @(negedge clk);
        hold = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b1001);
        checkOutput("hold_release_load", 4'b1001);
`endif

        model = int'(y);
        for (int n = 0; n < 300; n++) begin
            logic            r_ld;
            logic            r_dr;
            logic            r_er;
            logic            r_el;
            logic [SIZE-1:0] r_e;
            r_ld = ($urandom_range(0, 3) == 0);
            r_dr = 1'($urandom_range(0, 1));
            r_er = 1'($urandom_range(0, 1));
            r_el = 1'($urandom_range(0, 1));
            r_e  = SIZE'($urandom_range(0, (1 << SIZE) - 1));
            model = ref_next(model, r_ld, r_dr, r_er, r_el, int'(r_e));
            applyStimulus(r_ld, r_dr, r_er, r_el, r_e);
            checkOutput($sformatf("rand%0d", n), SIZE'(model));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
